// File: rtl/ps2_event_rx.sv
// PS/2 keyboard receiver: frames -> {break, extended, code} events in a FIFO, plus live modifier state.
// Latency: 2 clk from the filtered ps2_clk stop-bit falling edge to evt_valid on an empty FIFO.
// Backpressure: evt_valid/evt_ready handshake; events arriving at a full FIFO are dropped with ovf_pulse.
//
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   ps2_clk, ps2_data     raw asynchronous PS/2 pad inputs
//   evt_valid/evt_ready   FIFO head handshake, evt_data = {break, extended, code[7:0]}
//   fifo_count            events stored
//   mods                  {caps_lock, alt, ctrl, shift}
//   err_pulse, ovf_pulse  discarded-frame / dropped-event strobes
//   err_count             saturating count of cycles with either strobe

// Generic first-word-fall-through FIFO: head is visible whenever count != 0.
// Latency: 1 clk from push to head visible.
// Backpressure: caller must only push when !full, or when full with a pop in the same cycle.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic          full,
  output logic [AW:0]   count,
  output logic [DW-1:0] head
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  // count never exceeds 2**AW, so its MSB alone flags full
  assign full  = count_q[AW];
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_vld) mem_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_vld) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_vld && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push_vld) count_q <= count_q - (AW+1)'(1);
    end
  end
endmodule

module ps2_event_rx #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int FIFO_AW         = 3,
  parameter int PUSH_BREAKS     = 1,
  parameter int ERR_CNT_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [9:0]              evt_data,
  output logic [FIFO_AW:0]        fifo_count,
  output logic [3:0]              mods,
  output logic                    err_pulse,
  output logic                    ovf_pulse,
  output logic [ERR_CNT_BITS-1:0] err_count
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXT  = 2'd1;
  localparam logic [1:0] ST_BRK  = 2'd2;

  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic filt_q, filt_d, filt_prev_q;
  logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [9:0] sr_q, sr_d;
  logic [1:0] state_q, state_d;
  logic ext_q, ext_d;
  logic [7:0] mod_q, mod_d;  // {caps, caps_held, ralt, lalt, rctrl, lctrl, rshift, lshift}
  logic evt_stb_q, evt_stb_d;
  logic [9:0] evt_dat_q, evt_dat_d;
  logic err_pulse_q, ovf_pulse_q;
  logic [ERR_CNT_BITS-1:0] err_cnt_q;

  logic fall, to_hit, byte_vld, frame_err, is_prefix, key_evt, ev_brk;
  logic [7:0] rx_byte;
  logic [8:0] key;
  logic fifo_full, fifo_pop, fifo_push, ovf_d, err_d;
  logic [9:0] fifo_head;

  // Filter: the synchronised level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive samples before it is taken.
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (deb_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) filt_d = clk_s2_q;
      else deb_cnt_d = deb_cnt_q + DBW'(1);
    end
  end

  assign fall   = filt_prev_q && !filt_q;
  assign to_hit = (bit_cnt_q != 4'd0) && filt_q && (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = '0;
    if (bit_cnt_q != 4'd0 && filt_q && !to_hit) to_cnt_d = to_cnt_q + TOW'(1);
  end

  // Bits shift in from the top; after ten edges sr_q = {parity, data[7:0], start}.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    if (to_hit) begin
      bit_cnt_d = 4'd0;
    end else if (fall) begin
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (!sr_q[0] && dat_s2_q && (^sr_q[9:1])) byte_vld  = 1'b1;
        else                                       frame_err = 1'b1;
      end else begin
        sr_d      = {dat_s2_q, sr_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end
  end

  assign rx_byte   = sr_q[8:1];
  assign ev_brk    = (state_q == ST_BRK);
  assign is_prefix = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
  assign key_evt   = byte_vld && !is_prefix;
  assign key       = {ext_q, rx_byte};

  always_comb begin
    state_d   = state_q;
    ext_d     = ext_q;
    evt_stb_d = 1'b0;
    evt_dat_d = evt_dat_q;
    if (frame_err || to_hit) begin
      state_d = ST_IDLE;
      ext_d   = 1'b0;
    end else if (byte_vld) begin
      if (rx_byte == 8'hE0) begin
        ext_d   = 1'b1;
        state_d = ev_brk ? ST_BRK : ST_EXT;
      end else if (rx_byte == 8'hF0) begin
        state_d = ST_BRK;
      end else begin
        evt_stb_d = (PUSH_BREAKS != 0) || !ev_brk;
        evt_dat_d = {ev_brk, ext_q, rx_byte};
        state_d   = ST_IDLE;
        ext_d     = 1'b0;
      end
    end
  end

  // Modifiers follow every decoded event, enqueued or not.
  always_comb begin
    mod_d = mod_q;
    if (key_evt) begin
      case (key)
        9'h012: mod_d[0] = !ev_brk;
        9'h059: mod_d[1] = !ev_brk;
        9'h014: mod_d[2] = !ev_brk;
        9'h114: mod_d[3] = !ev_brk;
        9'h011: mod_d[4] = !ev_brk;
        9'h111: mod_d[5] = !ev_brk;
        9'h058: begin
          // typematic repeats of a held caps key must not toggle again
          if (ev_brk) begin
            mod_d[6] = 1'b0;
          end else begin
            if (!mod_q[6]) mod_d[7] = !mod_q[7];
            mod_d[6] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_pop  = evt_valid && evt_ready;
  assign fifo_push = evt_stb_q && (!fifo_full || fifo_pop);
  assign ovf_d     = evt_stb_q && fifo_full && !fifo_pop;
  assign err_d     = frame_err || to_hit;

  sync_fifo #(.DW(10), .AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (fifo_push),
    .push_dat (evt_dat_q),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      deb_cnt_q   <= '0;
      to_cnt_q    <= '0;
      bit_cnt_q   <= 4'd0;
      sr_q        <= '0;
      state_q     <= ST_IDLE;
      ext_q       <= 1'b0;
      mod_q       <= '0;
      evt_stb_q   <= 1'b0;
      evt_dat_q   <= '0;
      err_pulse_q <= 1'b0;
      ovf_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      deb_cnt_q   <= deb_cnt_d;
      to_cnt_q    <= to_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      state_q     <= state_d;
      ext_q       <= ext_d;
      mod_q       <= mod_d;
      evt_stb_q   <= evt_stb_d;
      evt_dat_q   <= evt_dat_d;
      err_pulse_q <= err_d;
      ovf_pulse_q <= ovf_d;
      // both strobes in one cycle count once
      if ((err_d || ovf_d) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_BITS'(1);
    end
  end

  assign evt_valid = (fifo_count != '0);
  assign evt_data  = evt_valid ? fifo_head : 10'h000;
  assign mods      = {mod_q[7], mod_q[5] | mod_q[4], mod_q[3] | mod_q[2], mod_q[1] | mod_q[0]};
  assign err_pulse = err_pulse_q;
  assign ovf_pulse = ovf_pulse_q;
  assign err_count = err_cnt_q;
endmodule

// File: tb/tb_ps2_event_rx.sv
module tb_ps2_event_rx;
  localparam int AW = 2;
  localparam int PB = 1;

  logic clk = 1'b0;
  logic reset_n, ps2_clk, ps2_data, evt_ready;
  logic evt_valid, err_pulse, ovf_pulse;
  logic [9:0] evt_data;
  logic [AW:0] fifo_count;
  logic [3:0] mods;
  logic [7:0] err_count;

  ps2_event_rx #(
    .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64), .FIFO_AW(AW), .PUSH_BREAKS(PB), .ERR_CNT_BITS(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .fifo_count(fifo_count), .mods(mods), .err_pulse(err_pulse), .ovf_pulse(ovf_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: key-level view of the keyboard stream.
  logic [9:0] exp_q[$];
  logic [511:0] held;
  logic m_caps, m_brk, m_ext;
  int exp_err, exp_ovf, obs_err, obs_ovf, pop_cnt;
  logic [9:0] last_pop;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] model_mods();
    return {m_caps, held[9'h011] | held[9'h111], held[9'h014] | held[9'h114],
            held[9'h012] | held[9'h059]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    held = '0; m_caps = 0; m_brk = 0; m_ext = 0;
    exp_err = 0; exp_ovf = 0; obs_err = 0; obs_ovf = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [8:0] k;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = {m_ext, b};
      if (k == 9'h058 && !m_brk && !held[k]) m_caps = !m_caps;
      held[k] = !m_brk;
      if (PB != 0 || !m_brk) begin
        if (!evt_ready && exp_q.size() == 2**AW) exp_ovf++;
        else exp_q.push_back({m_brk, m_ext, b});
      end
      m_brk = 0; m_ext = 0;
    end
  endtask

  task automatic model_err();
    exp_err++; m_brk = 0; m_ext = 0;
  endtask

  // Compare process: every handshake against the model, stall stability, strobes.
  logic stall_v = 0;
  logic [9:0] stall_d;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_v = 0;
    end else begin
      if (stall_v && evt_valid) chk("stall_hold", evt_data, stall_d);
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got %0h required none", evt_data);
        end else begin
          chk("evt_data", evt_data, exp_q.pop_front());
        end
        last_pop = evt_data;
        pop_cnt++;
      end
      if (err_pulse) obs_err++;
      if (ovf_pulse) obs_ovf++;
      stall_v = evt_valid && !evt_ready;
      stall_d = evt_data;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_clk(8);
      ps2_clk = 0;
      wait_clk(8);
      ps2_clk = 1;
    end
    ps2_data = 1;
    wait_clk(12);
  endtask

  task automatic post_checks();
    int sat;
    sat = exp_err + exp_ovf;
    if (sat > 255) sat = 255;
    chk("mods", mods, model_mods());
    chk("err_pulses", obs_err, exp_err);
    chk("ovf_pulses", obs_ovf, exp_ovf);
    chk("err_count", err_count, sat);
    if (evt_ready) chk("drained", exp_q.size(), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good);
    if (good) model_byte(b); else model_err();
    send_bits({1'b1, good ? ~^b : ^b, b, 1'b0}, 11);
    post_checks();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, evt_valid, 0);
    chk({tag, "_data"}, evt_data, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_mods"}, mods, 0);
    chk({tag, "_errp"}, err_pulse, 0);
    chk({tag, "_ovfp"}, ovf_pulse, 0);
    chk({tag, "_errc"}, err_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset_n = 0; ps2_clk = 1; ps2_data = 1; evt_ready = 1;
    pop_cnt = 0; last_pop = '0;
    model_reset();
    wait_clk(5);
    check_reset_outputs("rst0");
    #1 reset_n = 1;
    wait_clk(5);

    // single make
    send_byte(8'h1C, 1);
    chk("lit_1c", last_pop, 10'h01C);
    chk("lit_1c_mods", mods, 0);

    // extended break: E0 F0 75 yields one event
    p0 = pop_cnt;
    send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h75, 1);
    chk("lit_375", last_pop, 10'h375);
    chk("lit_375_cnt", pop_cnt - p0, 1);

    // shift make/break around another key
    send_byte(8'h12, 1);
    chk("lit_shift_on", mods[0], 1);
    send_byte(8'h1C, 1);
    chk("lit_shift_held", mods[0], 1);
    send_byte(8'hF0, 1); send_byte(8'h12, 1);
    chk("lit_shift_off", mods[0], 0);
    chk("lit_212", last_pop, 10'h212);

    // caps lock with typematic repeat
    send_byte(8'h58, 1); chk("lit_caps1", mods[3], 1);
    send_byte(8'h58, 1); chk("lit_caps2", mods[3], 1);
    send_byte(8'h58, 1); chk("lit_caps3", mods[3], 1);
    send_byte(8'hF0, 1); send_byte(8'h58, 1); chk("lit_caps_brk", mods[3], 1);
    send_byte(8'h58, 1); chk("lit_caps_off", mods[3], 0);

    // parity error, then timeout on a partial frame
    p0 = pop_cnt;
    send_byte(8'h1C, 0);
    chk("lit_par_errc", err_count, 1);
    chk("lit_par_noevt", pop_cnt - p0, 0);
    model_err();
    send_bits(11'h000, 5);
    wait_clk(100);
    post_checks();
    chk("lit_to_errc", err_count, 2);

    // overflow with consumer stalled
    evt_ready = 0;
    send_byte(8'h15, 1); send_byte(8'h1D, 1); send_byte(8'h24, 1);
    send_byte(8'h2D, 1); send_byte(8'h2C, 1);
    chk("lit_full_cnt", fifo_count, 4);
    chk("lit_ovf", obs_ovf, 1);
    chk("lit_head", evt_data, 10'h015);
    chk("lit_ovf_errc", err_count, 3);
    p0 = pop_cnt;
    evt_ready = 1;
    wait_clk(10);
    chk("lit_drain_n", pop_cnt - p0, 4);
    chk("lit_drain_last", last_pop, 10'h02D);
    chk("lit_drain_cnt", fifo_count, 0);
    chk("drained", exp_q.size(), 0);

    // reset in the middle of a frame
    send_byte(8'h12, 1);
    chk("lit_pre_rst_mods", mods, 4'h1);
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6);
    reset_n = 0;
    wait_clk(2);
    check_reset_outputs("rst1");
    #1 reset_n = 1;
    model_reset();
    wait_clk(5);
    send_byte(8'h1C, 1);
    chk("lit_post_rst", last_pop, 10'h01C);
    chk("lit_post_rst_mods", mods, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
